hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Issue controller between instr_decode and execute. Keeps a per-register scoreboard of in-flight writes.
//  Stalls decode on RAW/WAW hazards and squashes the decode slot after a taken jump/branch.
//  Also holds a saturating stall counter for performance debug.
// PARAMETERS
//  N_REGS        32   architectural registers; reg 0 hardwired zero, never pending
//  WD_ADDR       $clog2(N_REGS)  register address width (localparam)
//  FLUSH_CYCLES  2    cycles o_flush is held after a taken jump (>=1)
//  WD_STALL_CNT  16   width of stall performance counter
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        reset, synchronous, active-low
//  i_dec_valid   in   1        decode slot holds a valid instruction
//  i_dec_rs1     in   WD_ADDR  source 1 address
//  i_dec_rs2     in   WD_ADDR  source 2 address
//  i_dec_use_rs1 in   1        instruction reads rs1
//  i_dec_use_rs2 in   1        instruction reads rs2
//  i_dec_rd      in   WD_ADDR  destination address
//  i_dec_wr      in   1        instruction writes rd
//  o_issue       out  1        decode slot issued this cycle (combinational)
//  o_stall       out  1        decode must hold its instruction (combinational)
//  i_wb_valid    in   1        writeback completes this cycle
//  i_wb_rd       in   WD_ADDR  writeback destination
//  i_jump_taken  in   1        execute resolved a taken jump/branch (1-cycle pulse)
//  o_flush       out  1        squash decode/fetch (registered)
//  o_pending     out  N_REGS   scoreboard, bit r = write to r in flight (registered)
//  o_stall_cnt   out  WD_STALL_CNT  saturating count of stall cycles (registered)
// BEHAVIOUR
//  Reset: o_pending='0, o_flush=0, o_stall_cnt=0, FSM=RUN, flush counter=0.
//  FSM states:
//   RUN: go to FLUSH on i_jump_taken.
//   FLUSH: o_flush=1, no issue. Counter loads FLUSH_CYCLES-1 on entry and decrements.
//          Return to RUN when the counter reaches 0. i_jump_taken while in FLUSH reloads the counter.
//  Hazard, evaluated combinationally from the current o_pending:
//   raw1 = use_rs1 & rs1!=0 & pend(rs1)
//   raw2 = use_rs2 & rs2!=0 & pend(rs2)
//   waw  = wr & rd!=0 & pend(rd)
//   hazard = raw1|raw2|waw
//  o_issue = i_dec_valid & state==RUN & !i_jump_taken & !hazard.
//  o_stall = i_dec_valid & !o_issue.
//  Scoreboard update, next cycle:
//   - wb clear: bit i_wb_rd is cleared when i_wb_valid=1.
//   - issue set: bit i_dec_rd is set when o_issue=1 & i_dec_wr=1 & rd!=0.
//   - Same rd cleared and set in the same cycle: set wins.
//   - Bit 0 is never set.
//   - Writebacks keep clearing bits in FLUSH; issued instructions are older than the jump and are never squashed.
//  o_stall_cnt increments on every cycle with o_stall=1 and saturates at all-ones. It does not count flush cycles.
//  Jump vs issue in the same cycle: the jump wins and the slot is squashed.
//  A wb to an rd that is not pending is ignored; no error.
//  Reset mid-FLUSH returns to RUN and clears the scoreboard.
//  Latency: issue decision has 0 cycles (combinational); scoreboard and o_flush take effect 1 cycle later.
// CONFIGURATION
//  ARRISKV_WB_BYPASS_EN defined:
//   - pend(r) = o_pending[r] & !(i_wb_valid & i_wb_rd==r).
//   - An instruction whose only hazard is the register being written back this cycle issues in that same cycle.
//  ARRISKV_WB_BYPASS_EN undefined:
//   - pend(r) = o_pending[r].
//   - Such an instruction stalls 1 extra cycle.
//   - o_issue has no combinational path from the i_wb_* inputs.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clk with random inputs -> o_pending=0, o_flush=0, o_stall_cnt=0, o_issue follows i_dec_valid.
//  2 RAW: issue rd=5 wr=1; next cycle rs1=5 use_rs1 -> o_stall=1 until i_wb_valid rd=5.
//    Bypass on: issue in the wb cycle. Bypass off: issue 1 cycle later. stall_cnt matches.
//  3 WAW plus x0: pending rd=7; new wr rd=7 -> stall.
//    Issue rd=0 wr=1 -> o_pending[0] stays 0, rs1=0 never stalls.
//  4 Jump: i_jump_taken with i_dec_valid=1 -> o_issue=0 that cycle, o_flush=1 for exactly FLUSH_CYCLES cycles.
//    A second jump during the flush restarts the count.
//  5 Simultaneous: o_pending[9]=1; wb rd=9 and issue wr rd=9 in the same cycle (bypass on) -> o_pending[9] stays 1.
//  6 Saturation: force continuous stall 2^WD_STALL_CNT+3 cycles -> o_stall_cnt holds all-ones, no wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Issue controller: per-register scoreboard of in-flight writes, RAW/WAW stall, jump flush, stall perf counter.
// Optional writeback bypass of the hazard check is enabled by defining ARRISKV_WB_BYPASS_EN.
module hazard_ctrl #(
   parameter int N_REGS       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int WD_STALL_CNT = 16,
   localparam int WD_ADDR     = $clog2(N_REGS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_dec_valid,
   input  logic [WD_ADDR-1:0]      i_dec_rs1,
   input  logic [WD_ADDR-1:0]      i_dec_rs2,
   input  logic                    i_dec_use_rs1,
   input  logic                    i_dec_use_rs2,
   input  logic [WD_ADDR-1:0]      i_dec_rd,
   input  logic                    i_dec_wr,
   output logic                    o_issue,
   output logic                    o_stall,
   input  logic                    i_wb_valid,
   input  logic [WD_ADDR-1:0]      i_wb_rd,
   input  logic                    i_jump_taken,
   output logic                    o_flush,
   output logic [N_REGS-1:0]       o_pending,
   output logic [WD_STALL_CNT-1:0] o_stall_cnt
);

   localparam int WD_FCNT = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [WD_FCNT-1:0]      FCNT_LOAD = WD_FCNT'(FLUSH_CYCLES - 1);
   localparam logic [WD_FCNT-1:0]      FCNT_ONE  = WD_FCNT'(1);
   localparam logic [WD_FCNT-1:0]      FCNT_ZERO = {WD_FCNT{1'b0}};
   localparam logic [WD_ADDR-1:0]      REG_ZERO  = {WD_ADDR{1'b0}};
   localparam logic [WD_STALL_CNT-1:0] CNT_MAX   = {WD_STALL_CNT{1'b1}};
   localparam logic [WD_STALL_CNT-1:0] CNT_ONE   = WD_STALL_CNT'(1);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t                  state_r;
   logic [WD_FCNT-1:0]      fcnt_r;
   logic                    flush_r;
   logic [N_REGS-1:0]       pending_r;
   logic [WD_STALL_CNT-1:0] stall_cnt_r;

   logic [N_REGS-1:0] wb_clr_s;
   logic [N_REGS-1:0] iss_set_s;
   logic [N_REGS-1:0] pend_s;
   logic [N_REGS-1:0] pending_nxt_s;
   logic              raw1_s;
   logic              raw2_s;
   logic              waw_s;
   logic              hazard_s;
   logic              issue_s;
   logic              stall_s;

   // Writeback clear mask and the pending view used by the hazard check
   always_comb begin
      wb_clr_s = {N_REGS{1'b0}};
      if (i_wb_valid) begin
         wb_clr_s[i_wb_rd] = 1'b1;
      end else begin
         wb_clr_s = {N_REGS{1'b0}};
      end
`ifdef ARRISKV_WB_BYPASS_EN
      pend_s = pending_r & ~wb_clr_s;
`else
      pend_s = pending_r;
`endif
   end

   // Hazard detection and issue/stall decision
   always_comb begin
      raw1_s   = i_dec_use_rs1 & (i_dec_rs1 != REG_ZERO) & pend_s[i_dec_rs1];
      raw2_s   = i_dec_use_rs2 & (i_dec_rs2 != REG_ZERO) & pend_s[i_dec_rs2];
      waw_s    = i_dec_wr      & (i_dec_rd  != REG_ZERO) & pend_s[i_dec_rd];
      hazard_s = raw1_s | raw2_s | waw_s;
      issue_s  = i_dec_valid & (state_r == ST_RUN) & ~i_jump_taken & ~hazard_s;
      stall_s  = i_dec_valid & ~issue_s;
   end

   // Next scoreboard: writeback clears first, an issued write then sets (set wins)
   always_comb begin
      iss_set_s = {N_REGS{1'b0}};
      if (issue_s && i_dec_wr && (i_dec_rd != REG_ZERO)) begin
         iss_set_s[i_dec_rd] = 1'b1;
      end else begin
         iss_set_s = {N_REGS{1'b0}};
      end
      pending_nxt_s    = (pending_r & ~wb_clr_s) | iss_set_s;
      pending_nxt_s[0] = 1'b0;
   end

   // Run/flush FSM with its reload counter and registered flush output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
         fcnt_r  <= FCNT_ZERO;
         flush_r <= 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (i_jump_taken) begin
                  state_r <= ST_FLUSH;
                  fcnt_r  <= FCNT_LOAD;
                  flush_r <= 1'b1;
               end else begin
                  flush_r <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (i_jump_taken) begin
                  fcnt_r  <= FCNT_LOAD;
                  flush_r <= 1'b1;
               end else if (fcnt_r == FCNT_ZERO) begin
                  state_r <= ST_RUN;
                  flush_r <= 1'b0;
               end else begin
                  fcnt_r  <= fcnt_r - FCNT_ONE;
                  flush_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_RUN;
               fcnt_r  <= FCNT_ZERO;
               flush_r <= 1'b0;
            end
         endcase
      end
   end

   // Scoreboard register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_r <= {N_REGS{1'b0}};
      end else begin
         pending_r <= pending_nxt_s;
      end
   end

   // Saturating stall counter; stalls caused by the flush window are not counted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_r <= {WD_STALL_CNT{1'b0}};
      end else if (stall_s && (state_r == ST_RUN) && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign o_issue     = issue_s;
   assign o_stall     = stall_s;
   assign o_flush     = flush_r;
   assign o_pending   = pending_r;
   assign o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a per-cycle behavioural model.
module tb_hazard_ctrl;
   localparam int N_REGS = 32;
   localparam int AW     = 5;
   localparam int FC     = 3;
   localparam int W      = 16;
`ifdef ARRISKV_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_dec_valid, i_dec_use_rs1, i_dec_use_rs2, i_dec_wr;
   logic [AW-1:0] i_dec_rs1, i_dec_rs2, i_dec_rd, i_wb_rd;
   logic          o_issue, o_stall, i_wb_valid, i_jump_taken, o_flush;
   logic [N_REGS-1:0] o_pending;
   logic [W-1:0]  o_stall_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.N_REGS(N_REGS), .FLUSH_CYCLES(FC), .WD_STALL_CNT(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_dec_valid(i_dec_valid), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
      .i_dec_use_rs1(i_dec_use_rs1), .i_dec_use_rs2(i_dec_use_rs2),
      .i_dec_rd(i_dec_rd), .i_dec_wr(i_dec_wr),
      .o_issue(o_issue), .o_stall(o_stall),
      .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_jump_taken(i_jump_taken),
      .o_flush(o_flush), .o_pending(o_pending), .o_stall_cnt(o_stall_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: set of in-flight destinations, remaining flush cycles, stall count
   bit m_pend [N_REGS];
   int m_flush_left;
   int m_cnt;
   bit m_known = 1'b0;
   logic obs_issue, obs_stall, obs_flush;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_busy(input int r, input bit wbv, input int wbrd);
      if (r == 0) return 1'b0;
      if (BYPASS && wbv && (wbrd == r)) return 1'b0;
      return m_pend[r];
   endfunction

   task automatic cyc(input bit rn, input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wr, input bit wbv, input int wbrd, input bit jmp);
      bit haz, e_issue, e_stall;
      logic [N_REGS-1:0] e_pend;
      rst_n = rn; i_dec_valid = v; i_dec_rs1 = AW'(rs1); i_dec_use_rs1 = u1;
      i_dec_rs2 = AW'(rs2); i_dec_use_rs2 = u2; i_dec_rd = AW'(rd); i_dec_wr = wr;
      i_wb_valid = wbv; i_wb_rd = AW'(wbrd); i_jump_taken = jmp;
      @(negedge clk);
      haz = (u1 && m_busy(rs1, wbv, wbrd)) || (u2 && m_busy(rs2, wbv, wbrd)) || (wr && m_busy(rd, wbv, wbrd));
      e_issue = v && (m_flush_left == 0) && !jmp && !haz;
      e_stall = v && !e_issue;
      for (int i = 0; i < N_REGS; i++) e_pend[i] = m_pend[i];
      obs_issue = o_issue; obs_stall = o_stall; obs_flush = o_flush;
      if (m_known) begin
         check_val("issue", {63'd0, o_issue}, {63'd0, e_issue});
         check_val("stall", {63'd0, o_stall}, {63'd0, e_stall});
         check_val("flush", {63'd0, o_flush}, {63'd0, m_flush_left > 0});
         check_val("pending", 64'(o_pending), 64'(e_pend));
         check_val("stall_cnt", 64'(o_stall_cnt), 64'(m_cnt));
      end
      @(posedge clk);
      if (!rn) begin
         for (int i = 0; i < N_REGS; i++) m_pend[i] = 1'b0;
         m_flush_left = 0; m_cnt = 0; m_known = 1'b1;
      end else if (m_known) begin
         if (e_stall && m_flush_left == 0 && m_cnt < (2**W - 1)) m_cnt++;
         if (wbv) m_pend[wbrd] = 1'b0;
         if (e_issue && wr && rd != 0) m_pend[rd] = 1'b1;
         if (jmp) m_flush_left = FC;
         else if (m_flush_left > 0) m_flush_left--;
      end
      #1;
   endtask

   task automatic idle(input int wbv, input int wbrd);
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, wbv[0], wbrd, 1'b0);
   endtask

   initial begin
      int c0, nf;
      bit rv;
      rst_n = 1'b0; i_dec_valid = 1'b0; i_dec_rs1 = '0; i_dec_rs2 = '0; i_dec_use_rs1 = 1'b0;
      i_dec_use_rs2 = 1'b0; i_dec_rd = '0; i_dec_wr = 1'b0; i_wb_valid = 1'b0; i_wb_rd = '0;
      i_jump_taken = 1'b0;
      m_flush_left = 0; m_cnt = 0;

      // Reset with random decode inputs
      for (int k = 0; k < 3; k++) begin
         rv = 1'($urandom);
         cyc(1'b0, rv, $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31), 1'($urandom),
             $urandom_range(0, 31), 1'($urandom), 1'($urandom), $urandom_range(0, 31), 1'b0);
         if (k > 0) check_val("rst_issue_follows_valid", {63'd0, obs_issue}, {63'd0, rv});
      end
      check_val("rst_pending", 64'(o_pending), 64'd0);
      check_val("rst_flush", {63'd0, o_flush}, 64'd0);
      check_val("rst_cnt", 64'(o_stall_cnt), 64'd0);

      // RAW on r5
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 0, 1'b0);
      check_val("raw_first_issue", {63'd0, obs_issue}, 64'd1);
      check_val("raw_pend5", {63'd0, o_pending[5]}, 64'd1);
      c0 = int'(o_stall_cnt);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
         check_val("raw_stall", {63'd0, obs_stall}, 64'd1);
      end
      cyc(1'b1, 1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5, 1'b0);
      check_val("raw_wb_cycle_issue", {63'd0, obs_issue}, {63'd0, BYPASS});
      if (!BYPASS) begin
         cyc(1'b1, 1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
         check_val("raw_after_wb_issue", {63'd0, obs_issue}, 64'd1);
      end
      check_val("raw_stall_cnt_delta", 64'(int'(o_stall_cnt) - c0), BYPASS ? 64'd3 : 64'd4);

      // WAW on r7 and x0 behaviour
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0);
      check_val("waw_stall", {63'd0, obs_stall}, 64'd1);
      idle(1, 7);
      cyc(1'b1, 1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
      check_val("x0_issue", {63'd0, obs_issue}, 64'd1);
      check_val("x0_not_pending", {63'd0, o_pending[0]}, 64'd0);

      // Jump squashes the slot and flushes FC cycles; a second jump restarts the count
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 0, 1'b1);
      check_val("jump_squash", {63'd0, obs_issue}, 64'd0);
      nf = 0;
      for (int k = 0; k < 10; k++) begin idle(0, 0); nf += int'(obs_flush); end
      check_val("flush_len", 64'(nf), 64'(FC));
      cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
      idle(0, 0);
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
      check_val("flush_during_rejump", {63'd0, obs_flush}, 64'd1);
      nf = 0;
      for (int k = 0; k < 10; k++) begin idle(0, 0); nf += int'(obs_flush); end
      check_val("flush_len_restart", 64'(nf), 64'(FC));

      // Writeback and re-issue of r9 in the same cycle
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1, 9, 1'b0);
      check_val("simul_issue", {63'd0, obs_issue}, {63'd0, BYPASS});
      check_val("simul_pend9", {63'd0, o_pending[9]}, {63'd0, BYPASS});
      if (!BYPASS) cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 0, 1'b0);
      check_val("simul_pend9_final", {63'd0, o_pending[9]}, 64'd1);

      // Random traffic, occasional mid-run resets
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
             $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
             $urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 99) < 35), $urandom_range(0, 7),
             ($urandom_range(0, 99) < 6));
      end

      // Stall counter saturation
      cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0);
      for (int k = 0; k < (2**W) + 3; k++) begin
         cyc(1'b1, 1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      end
      check_val("stall_cnt_saturated", 64'(o_stall_cnt), 64'((2**W) - 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
